neuron_layer_engine: RTL
========================

NEURON_LAYER_ENGINE -- requirements
Module: neuron_layer_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_IN, 4: layer-1 fan-in.
- N_H1, 4: layer-1 neurons.
- N_H2, 4: layer-2 neurons.
- N_OUT, 2: output neurons.
- ADDR_W, 8: weight address width.
- FRAC, 4: fractional bits of the Q-format.
REQ-002 The clock and reset SHALL be `clk` and `rst` on a single clock domain; `rst` is asynchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- start_neuron  in  1  layer request, held high by the controller until it samples calculation_done.
- state  in  2  layer select: 00 layer1, 01 layer2, 10 output, 11 illegal.
- hidden  in  1  apply ReLU to results.
- calculation_done  out  1  one-cycle layer-complete pulse.
- w_addr  out  ADDR_W  weight read address.
- w_data  in  8  signed weight; sync ROM, 1-cycle latency.
- a_addr  out  8  activation read index.
- a_data  in  8  signed activation; 1-cycle latency.
- r_we  out  1  result write strobe.
- r_addr  out  8  result neuron index.
- r_data  out  8  signed result.

Function
REQ-004 FSM states SHALL be IDLE, MAC, WRITE, DONE.
REQ-005 In IDLE with start_neuron=1, the block SHALL latch state and hidden, clear the neuron and input counters and the accumulator, and enter MAC next cycle.
REQ-006 start_neuron, state and hidden SHALL be ignored outside IDLE; the latched values govern the whole layer.
REQ-007 Fan-in/fan-out per latched state SHALL be: 00 -> N_IN/N_H1; 01 -> N_H1/N_H2; 10 -> N_H2/N_OUT.
REQ-008 Weight bases SHALL be B0=0, B1=N_IN*N_H1, B2=B1+N_H1*N_H2; w_addr = Bk + n*fan_in + i; a_addr = i.
REQ-009 MAC SHALL last fan_in+1 cycles per neuron:
- Cycles 0..fan_in-1 issue addresses i=0..fan_in-1.
- Cycles 1..fan_in accumulate w_data*a_data (16-bit signed product, sign-extended into a 24-bit signed accumulator).
REQ-010 WRITE SHALL last one cycle with r_we=1 and r_addr=n, then either:
- clear the accumulator and return to MAC for neuron n+1, or
- enter DONE after neuron fan_out-1.
REQ-011 r_data SHALL be computed in this order:
- arithmetic right shift of the accumulator by FRAC;
- if latched hidden=1, negative values -> 0;
- saturate to [-128, 127].
REQ-012 In DONE, calculation_done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-013 The start_neuron level still high in the cycle after DONE (next controller layer) SHALL start a new layer from IDLE.
REQ-014 calculation_done SHALL rise exactly 1 + fan_out*(fan_in+2) cycles after the IDLE cycle that sampled start_neuron=1.
REQ-015 Latched state=11 SHALL go IDLE -> DONE directly, with no r_we and calculation_done one cycle later.
REQ-016 r_we SHALL be asserted only in WRITE; w_addr, a_addr and r_addr SHALL hold 0 in IDLE and DONE.
REQ-017 Accumulator overflow SHALL NOT be detected; 24-bit width is sufficient for fan-in <= 255.

Reset
REQ-018 rst=0 SHALL asynchronously force the following, including mid-layer:
- FSM to IDLE;
- counters and accumulator to 0;
- calculation_done=0, r_we=0;
- w_addr, a_addr, r_addr, r_data to 0.
REQ-019 After reset release, no write or done pulse SHALL occur until a new start_neuron is sampled in IDLE.

Verification
REQ-020 Basic layer: N_IN=2, N_H1=2, state=00, hidden=1, all weights 16, activations 3 and 5 -> r_data=8 at r_addr 0 and 1; calculation_done 9 cycles after start.
REQ-021 ReLU/sign: weights -16, activations 3 and 5 -> r_data=0 with hidden=1; r_data=-8 with hidden=0.
REQ-022 Saturation: weights 127, activations 127, fan-in 2 -> r_data=127; weights 127, activations -128 -> r_data=-128 with hidden=0.
REQ-023 Back-to-back layers: start_neuron held high across state 00 -> 01 -> 10 -> three done pulses, each one cycle wide, latencies per REQ-014, with correct weight bases.
REQ-024 Illegal layer: state=11 with start -> calculation_done exactly 2 cycles after start, zero r_we.
REQ-025 Reset mid-MAC: rst low during neuron 1 -> all outputs 0 immediately; after release, no r_we or done until a fresh start.

Source files
------------

// File: rtl/neuron_layer_engine.sv
// Purpose : sequential MAC engine for one fully connected layer; it runs layer1, layer2 or output per request.
// Latency : calculation_done rises 1 + fan_out*(fan_in+2) cycles after start is taken (2 cycles for state 11).
// Backpres: no handshake; the caller holds start_neuron until it sees calculation_done; weight and activation reads return after 1 cycle.
// Ports   : clk/rst (async active-low); start_neuron/state/hidden = layer request;
//           w_addr/w_data, a_addr/a_data = synchronous memory reads;
//           r_we/r_addr/r_data = result write; calculation_done = completion pulse.
module neuron_layer_engine #(
  parameter int N_IN   = 4,
  parameter int N_H1   = 4,
  parameter int N_H2   = 4,
  parameter int N_OUT  = 2,
  parameter int ADDR_W = 8,
  parameter int FRAC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_neuron,
  input  logic [1:0]          state,
  input  logic                hidden,
  output logic                calculation_done,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic signed [7:0]   w_data,
  output logic [7:0]          a_addr,
  input  logic signed [7:0]   a_data,
  output logic                r_we,
  output logic [7:0]          r_addr,
  output logic signed [7:0]   r_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int B1 = N_IN * N_H1;
  localparam int B2 = B1 + N_H1 * N_H2;

  logic [1:0]         fsm_q, fsm_d;
  logic [1:0]         lyr_q, lyr_d;
  logic               relu_q, relu_d;
  logic               ill_q, ill_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         c_q, c_d;
  logic signed [23:0] acc_q, acc_d;

  logic [7:0]          fan_in, fan_out;
  logic [ADDR_W-1:0]   base;
  logic                issue;
  logic signed [15:0]  prod;
  logic signed [23:0]  shifted;
  logic signed [23:0]  relu_v;
  logic signed [7:0]   sat_v;

  // Geometry of the latched layer; the illegal code never reaches MAC.
  always_comb begin
    fan_in  = '0;
    fan_out = '0;
    base    = '0;
    case (lyr_q)
      2'd0: begin fan_in = 8'(N_IN); fan_out = 8'(N_H1);  base = '0;          end
      2'd1: begin fan_in = 8'(N_H1); fan_out = 8'(N_H2);  base = ADDR_W'(B1); end
      2'd2: begin fan_in = 8'(N_H2); fan_out = 8'(N_OUT); base = ADDR_W'(B2); end
      default: ;
    endcase
  end

  // MAC cycle c issues input c while c < fan_in; data for input c-1 lands in cycle c.
  assign issue  = (fsm_q == S_MAC) && (c_q < fan_in);
  assign w_addr = issue ? (base + ADDR_W'(n_q) * ADDR_W'(fan_in) + ADDR_W'(c_q)) : '0;
  assign a_addr = issue ? c_q : '0;

  assign prod = w_data * a_data;

  // Result path: scale down, optional ReLU, then clamp to int8.
  assign shifted = acc_q >>> FRAC;
  assign relu_v  = (relu_q && shifted[23]) ? 24'sd0 : shifted;
  always_comb begin
    if (relu_v > 24'sd127)        sat_v = 8'sd127;
    else if (relu_v < -24'sd128)  sat_v = -8'sd128;
    else                          sat_v = relu_v[7:0];
  end

  assign r_we             = (fsm_q == S_WRITE);
  assign r_addr           = ((fsm_q == S_MAC) || (fsm_q == S_WRITE)) ? n_q : '0;
  assign r_data           = r_we ? sat_v : '0;
  // An illegal request spends its first DONE cycle silent so the pulse lands two cycles after start.
  assign calculation_done = (fsm_q == S_DONE) && !ill_q;

  always_comb begin
    fsm_d  = fsm_q;
    lyr_d  = lyr_q;
    relu_d = relu_q;
    ill_d  = ill_q;
    n_d    = n_q;
    c_d    = c_q;
    acc_d  = acc_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_neuron) begin
          lyr_d  = state;
          relu_d = hidden;
          n_d    = '0;
          c_d    = '0;
          acc_d  = '0;
          if (state == 2'd3) begin
            ill_d = 1'b1;
            fsm_d = S_DONE;
          end else begin
            fsm_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (c_q != 8'd0) acc_d = acc_q + {{8{prod[15]}}, prod};
        if (c_q == fan_in) fsm_d = S_WRITE;
        else               c_d   = c_q + 8'd1;
      end
      S_WRITE: begin
        acc_d = '0;
        c_d   = '0;
        if (n_q == fan_out - 8'd1) begin
          fsm_d = S_DONE;
        end else begin
          n_d   = n_q + 8'd1;
          fsm_d = S_MAC;
        end
      end
      S_DONE: begin
        if (ill_q) ill_d = 1'b0;
        else       fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= S_IDLE;
      lyr_q  <= '0;
      relu_q <= 1'b0;
      ill_q  <= 1'b0;
      n_q    <= '0;
      c_q    <= '0;
      acc_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      lyr_q  <= lyr_d;
      relu_q <= relu_d;
      ill_q  <= ill_d;
      n_q    <= n_d;
      c_q    <= c_d;
      acc_q  <= acc_d;
    end
  end

endmodule
